// File: rtl/mlp_mem_pkg.sv
// Shared types and limits for the MLP weight/activation memory.
package mlp_mem_pkg;

  typedef enum logic {CLEAR, READY} sram_state_t;

  localparam int unsigned RD_LAT_MAX = 2;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line carrying {valid, data}; data only advances with valid,
// so the last stage holds the most recent result between reads.
module sram_rd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0] vld;
  logic [DATA_W-1:0] dat [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];

endmodule

// File: rtl/sram_bank.sv
// One-write/one-read memory bank with a post-reset/on-demand clear engine,
// write-first collision bypass and sticky out-of-range reporting.
module sram_bank
  import mlp_mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              oob_err
);

  localparam int unsigned STAGES =
    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  sram_state_t       state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in, rd_in;
  logic              wr_ok, wr_bad, rd_acc, rd_bad;
  logic [DATA_W-1:0] rd_word;

  assign ready  = (state == READY);
  assign wr_in  = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_ok  = ready & wr_en & wr_in;
  assign wr_bad = ready & wr_en & ~wr_in;
  assign rd_acc = ready & rd_en;
  assign rd_bad = ready & rd_en & ~rd_in;

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (ptr == LAST) state_nx = READY;
      READY:   if (clear_req)   state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  // An accepted clear_req wins over an out-of-range access in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      oob_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      else if (clear_req) ptr <= '0;
      if (ready && clear_req)  oob_err <= 1'b0;
      else if (wr_bad || rd_bad) oob_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_ok)     mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_word = '0;
    if (rd_in) rd_word = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (STAGES)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_sram_bank.sv
// Bench: two banks (8 words/latency 1 and 6 words/latency 2) share one
// stimulus stream; each is compared against its own behavioural model.
module tb_sram_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_req = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;

  logic        rdy [2];
  logic        rdv [2];
  logic        oob [2];
  logic [15:0] rdd [2];

  always #5 clk = ~clk;

  sram_bank #(.DATA_W(16), .DEPTH(8), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .rd_valid(rdv[0]), .oob_err(oob[0])
  );

  sram_bank #(.DATA_W(16), .DEPTH(6), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .ready(rdy[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .rd_valid(rdv[1]), .oob_err(oob[1])
  );

  int passed = 0;
  int total  = 0;

  // Reference model: per bank, word contents, readiness with remaining clear
  // edges, sticky error, and a short history of issued read results.
  int          dep [2] = '{8, 6};
  int          lat [2] = '{1, 2};
  logic [15:0] mm  [2][8];
  bit          mrdy [2];
  int          left [2];
  bit          moob [2];
  bit          hv  [2][2];
  logic [15:0] hd  [2][2];
  bit          mv  [2];
  logic [15:0] md  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mrdy[k] = 1'b0; left[k] = dep[k]; moob[k] = 1'b0;
      hv[k][0] = 1'b0; hv[k][1] = 1'b0; hd[k][0] = '0; hd[k][1] = '0;
      mv[k] = 1'b0; md[k] = '0;
    end
  endtask

  task automatic model_edge(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                            input logic re, input logic [2:0] ra, input logic cr);
    for (int k = 0; k < 2; k++) begin
      bit          nv = 1'b0;
      logic [15:0] nd = '0;
      if (mrdy[k]) begin
        if (re) begin
          nv = 1'b1;
          if (int'(ra) < dep[k]) nd = (we && wa == ra) ? wd : mm[k][ra];
          else moob[k] = 1'b1;
        end
        if (we) begin
          if (int'(wa) < dep[k]) mm[k][wa] = wd;
          else moob[k] = 1'b1;
        end
        if (cr) begin
          mrdy[k] = 1'b0; left[k] = dep[k]; moob[k] = 1'b0;
        end
      end else begin
        left[k]--;
        if (left[k] == 0) begin
          mrdy[k] = 1'b1;
          for (int i = 0; i < 8; i++) mm[k][i] = '0;
        end
      end
      hv[k][1] = hv[k][0]; hd[k][1] = hd[k][0];
      hv[k][0] = nv;       hd[k][0] = nd;
      mv[k] = hv[k][lat[k]-1];
      if (mv[k]) md[k] = hd[k][lat[k]-1];
    end
  endtask

  task automatic check_all(input string phase);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.d%0d.ready", phase, k),    rdy[k], mrdy[k]);
      chk($sformatf("%s.d%0d.rd_valid", phase, k), rdv[k], mv[k]);
      chk($sformatf("%s.d%0d.rd_data", phase, k),  rdd[k], md[k]);
      chk($sformatf("%s.d%0d.oob_err", phase, k),  oob[k], moob[k]);
    end
  endtask

  task automatic step(input string phase, input logic we, input logic [2:0] wa,
                      input logic [15:0] wd, input logic re, input logic [2:0] ra,
                      input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; clear_req = cr;
    @(posedge clk);
    model_edge(we, wa, wd, re, ra, cr);
    #1;
    check_all(phase);
  endtask

  task automatic idle(input string phase);
    step(phase, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wait_ready(input string phase);
    for (int n = 0; n < 20 && !(rdy[0] && rdy[1]); n++) idle(phase);
    chk({phase, ".wait_ready"}, rdy[0] & rdy[1], 1'b1);
  endtask

  task automatic assert_reset(input string phase);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(phase);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int edges;
    #2;
    assert_reset("reset");

    // Test 1: clear timing, then every word reads zero
    for (int i = 0; i < 8; i++) idle("t1.clear");
    chk("t1.ready_after_8", rdy[0], 1'b1);
    for (int a = 0; a < 8; a++) begin
      step("t1.read", 1'b0, 3'd0, 16'h0, 1'b1, 3'(a), 1'b0);
      chk("t1.data0", rdd[0], 16'h0000);
      chk("t1.pulse0", rdv[0], 1'b1);
    end
    idle("t1.tail");
    idle("t1.tail");
    chk("t1.novalid0", rdv[0], 1'b0);

    // Test 2: write then read, value held while idle
    step("t2.wr", 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0);
    step("t2.rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0);
    chk("t2.data", rdd[0], 16'hBEEF);
    chk("t2.valid", rdv[0], 1'b1);
    for (int i = 0; i < 3; i++) idle("t2.idle");
    chk("t2.hold", rdd[0], 16'hBEEF);
    chk("t2.novalid", rdv[0], 1'b0);

    // Test 3: write-first collision
    step("t3.wr", 1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0, 1'b0);
    step("t3.col", 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b0);
    chk("t3.data", rdd[0], 16'h1234);
    idle("t3.idle");
    chk("t3.d1data", rdd[1], 16'h1234);

    // Test 4: latency-2 back-to-back reads
    for (int i = 0; i < 4; i++)
      step("t4.wr", 1'b1, 3'(i), 16'(16'h0011 * (i + 1)), 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("t4.rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0);
      if (i == 0) chk("t4.first_novalid", rdv[1], 1'b0);
      else begin
        chk("t4.valid", rdv[1], 1'b1);
        chk("t4.data", rdd[1], 16'(16'h0011 * i));
      end
    end
    idle("t4.drain");
    chk("t4.last_valid", rdv[1], 1'b1);
    chk("t4.last_data", rdd[1], 16'h0044);
    idle("t4.drain");
    chk("t4.end_novalid", rdv[1], 1'b0);

    // Clear error state before the out-of-range test
    step("t5.clr", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
    wait_ready("t5.clr");
    chk("t5.oob_cleared", oob[1], 1'b0);

    // Test 5: out-of-range write and read on the 6-word bank
    step("t5.wr", 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 1'b0);
    chk("t5.oob_set", oob[1], 1'b1);
    chk("t5.d0_no_oob", oob[0], 1'b0);
    step("t5.rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b0);
    chk("t5.d0_data", rdd[0], 16'h7777);
    idle("t5.drain");
    chk("t5.d1_valid", rdv[1], 1'b1);
    chk("t5.d1_data", rdd[1], 16'h0000);
    chk("t5.oob_sticky", oob[1], 1'b1);
    for (int a = 0; a < 6; a++) step("t5.scan", 1'b0, 3'd0, 16'h0, 1'b1, 3'(a), 1'b0);
    idle("t5.drain");
    idle("t5.drain");

    // Randomised traffic with occasional clears
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 39) == 0));
    wait_ready("rand.end");

    // Test 6: clear with ignored write, then reset mid-clear
    step("t6.wr", 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 1'b0);
    step("t6.oob", 1'b1, 3'd7, 16'h1111, 1'b0, 3'd0, 1'b0);
    step("t6.clr", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
    chk("t6.ready_low", rdy[1], 1'b0);
    step("t6.ignored_wr", 1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 1'b0);
    chk("t6.no_valid", rdv[0], 1'b0);
    wait_ready("t6.clear");
    chk("t6.oob_zero", oob[1], 1'b0);
    for (int a = 0; a < 6; a++) step("t6.scan", 1'b0, 3'd0, 16'h0, 1'b1, 3'(a), 1'b0);
    idle("t6.drain");
    chk("t6.addr5_zero", rdd[1], 16'h0000);
    idle("t6.drain");

    step("t6.clr2", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) idle("t6.partial");
    assert_reset("t6.reset");
    edges = 0;
    for (int n = 0; n < 20 && !rdy[1]; n++) begin
      idle("t6.restart");
      edges++;
    end
    chk("t6.restart_edges", edges, 6);
    wait_ready("t6.final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_bank.md
Name: sram_bank

Overview:
- Clocked, parametrised successor to the team's single-port behavioural memory: one write port, one read port, configurable width, depth and read latency.
- Built-in clear engine zeroes every word after reset and on request.
- Holds MLP weights and activations between the layer controller and the neuron datapath.
- Reports out-of-range accesses instead of silently aliasing.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 64, number of words (need not be a power of two, >= 2).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- ADDR_W, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_req  in  1  pulse; starts a full clear when ready=1.
- ready  out  1  high when accesses are accepted; low while clearing.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read result; holds last value between reads.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- oob_err  out  1  sticky; set by any access with address >= DEPTH.

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, ready=0, oob_err=0, clear pointer=0, FSM=CLEAR, read pipeline flushed. Memory array is not reset; the clear engine zeroes it.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[ptr], then ptr++. The cycle that writes ptr=DEPTH-1 transitions to READY. ready asserts at edge DEPTH after the first edge with rst low.
  - READY: accepts accesses. clear_req=1 -> CLEAR with ptr=0 and oob_err cleared; ready drops at the next edge.
- clear_req in CLEAR is ignored.
- rst asserted mid-clear restarts the clear from ptr=0.
- In CLEAR, wr_en and rd_en are ignored: no write, no rd_valid, no oob_err update.
- Write (READY, wr_en=1, wr_addr<DEPTH): mem[wr_addr] <= wr_data at the edge.
- Out-of-range write (wr_addr>=DEPTH): dropped; oob_err <= 1.
- Read (READY, rd_en=1): rd_addr sampled at edge N. rd_data/rd_valid are presented after edge N+RD_LAT-1 and are valid for the cycle following it.
  - RD_LAT=1: registered output.
  - RD_LAT=2: one additional output register stage.
  - Fully pipelined: one read per cycle, results in issue order, no bubbles.
- Out-of-range read: returns 0 with rd_valid=1 at normal latency; oob_err <= 1.
- Collision (rd_en and wr_en to the same in-range address, same cycle): write-first; the read returns the new wr_data.
- Reads in flight when clear_req is accepted complete normally with pre-clear data. No new reads are accepted once in CLEAR.
- rd_valid is 0 in any cycle without a completing read. rd_data keeps its last value.
- oob_err clears only on rst or an accepted clear_req.

Decomposition:
- Package mlp_mem_pkg:
  - typedef enum {CLEAR, READY} sram_state_t.
  - constant RD_LAT_MAX=2.
- Sub-module sram_rd_pipe: parametrised delay line (DATA_W+1 bits, RD_LAT stages) carrying {valid, data}, with async reset to zero.
- Storage array, FSM and collision bypass stay in sram_bank.

Test Plan:
1. DATA_W=16, DEPTH=8, RD_LAT=1; release rst -> ready=0 for exactly 8 edges, then 1; read addrs 0..7 -> rd_data=0x0000 each, one rd_valid pulse per read.
2. Write 0xBEEF to addr 3, read addr 3 next cycle -> rd_data=0xBEEF with rd_valid one cycle after rd_en; rd_data still 0xBEEF three idle cycles later, rd_valid=0.
3. Same-cycle write 0x1234 and read to addr 5 (old value 0xAAAA) -> rd_data=0x1234.
4. RD_LAT=2; write 0x0011,0x0022,0x0033,0x0044 to addrs 0..3; back-to-back reads 0..3 -> four consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in order.
5. DEPTH=6 (ADDR_W=3): write 0x7777 to addr 7 -> no array change, oob_err=1; read addr 7 -> rd_data=0, rd_valid=1; oob_err stays 1.
6. After tests 2/5, pulse clear_req -> ready low for 6 edges; wr_en to addr 2 during clear is ignored; then all addrs read 0 and oob_err=0. Asserting rst at ptr=3 mid-clear restarts the full 6-edge clear.
